// File: rtl/fwd_select_ctrl_pkg.sv
// Shared constants for the EX-stage operand forwarding selector.
// Selector codes are the 4:1 mux select values seen by EX.
package fwd_select_ctrl_pkg;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [1:0] SEL_IMM   = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_select_ctrl_if.sv
// ID-stage issue bundle plus the forwarding/stall controls returned to it.
// The master side drives ID fields; the slave is the select controller.
interface fwd_select_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             hold;
  logic             flush;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_b_imm;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic [1:0]       sel_a;
  logic [1:0]       sel_b;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output hold, flush, id_valid, id_rs, id_rt,
    output id_use_rs, id_use_rt, id_b_imm,
    output id_rd, id_reg_write, id_mem_read,
    input  sel_a, sel_b, stall, bubble, stall_count
  );

  modport slave (
    input  hold, flush, id_valid, id_rs, id_rt,
    input  id_use_rs, id_use_rt, id_b_imm,
    input  id_rd, id_reg_write, id_mem_read,
    output sel_a, sel_b, stall, bubble, stall_count
  );
endinterface

// File: rtl/fwd_select_ctrl_fwd_src_pick.sv
// Match-and-priority forwarding source pick for one operand.
// The youngest producer (EX) wins over MEM; $0 never forwards.
module fwd_src_pick
  import fwd_select_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] r,
  input  logic             use_r,
  input  logic             ex_vld,
  input  logic             ex_wr,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_vld,
  input  logic             mem_wr,
  input  logic [REG_W-1:0] mem_rd,
  output logic             hit_ex,
  output logic [1:0]       sel
);

  logic nz;
  logic hit_mem;

  assign nz      = r != REG_W'(REG_ZERO);
  assign hit_ex  = ex_vld & ex_wr & (ex_rd == r) & nz;
  assign hit_mem = mem_vld & mem_wr & (mem_rd == r) & nz;

  always_comb begin
    sel = SEL_RF;
    if (!use_r)       sel = SEL_RF;
    else if (hit_ex)  sel = SEL_EXMEM;
    else if (hit_mem) sel = SEL_MEMWB;
  end

endmodule

// File: rtl/fwd_select_ctrl.sv
// Registered EX operand selectors, EX/MEM destination tracking,
// and one-cycle load-use stall with a saturating stall counter.
module fwd_select_ctrl
  import fwd_select_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  fwd_select_ctrl_if.slave io
);

  logic             ex_vld_q, ex_vld_d;
  logic             ex_wr_q, ex_wr_d;
  logic             ex_ld_q, ex_ld_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d;
  logic             mem_vld_q, mem_vld_d;
  logic             mem_wr_q, mem_wr_d;
  logic [REG_W-1:0] mem_rd_q, mem_rd_d;
  logic [1:0]       sel_a_q, sel_a_d;
  logic [1:0]       sel_b_q, sel_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       hit_a, hit_b;
  logic [1:0] pick_a, pick_b;
  logic       lu;
  logic       stall;
  logic       bubble;

  fwd_src_pick #(.REG_W(REG_W)) u_pick_a (
    .r(io.id_rs), .use_r(io.id_use_rs),
    .ex_vld(ex_vld_q), .ex_wr(ex_wr_q), .ex_rd(ex_rd_q),
    .mem_vld(mem_vld_q), .mem_wr(mem_wr_q), .mem_rd(mem_rd_q),
    .hit_ex(hit_a), .sel(pick_a)
  );

  fwd_src_pick #(.REG_W(REG_W)) u_pick_b (
    .r(io.id_rt), .use_r(io.id_use_rt),
    .ex_vld(ex_vld_q), .ex_wr(ex_wr_q), .ex_rd(ex_rd_q),
    .mem_vld(mem_vld_q), .mem_wr(mem_wr_q), .mem_rd(mem_rd_q),
    .hit_ex(hit_b), .sel(pick_b)
  );

  assign lu = io.id_valid & ex_ld_q &
              ((io.id_use_rs & hit_a) | (io.id_use_rt & hit_b));
  assign stall  = lu & ~io.hold;
  assign bubble = (lu | io.flush) & ~io.hold;

  always_comb begin
    ex_vld_d  = ex_vld_q;
    ex_wr_d   = ex_wr_q;
    ex_ld_d   = ex_ld_q;
    ex_rd_d   = ex_rd_q;
    mem_vld_d = mem_vld_q;
    mem_wr_d  = mem_wr_q;
    mem_rd_d  = mem_rd_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    cnt_d     = cnt_q;
    if (!io.hold) begin
      mem_vld_d = ex_vld_q;
      mem_wr_d  = ex_wr_q;
      mem_rd_d  = ex_rd_q;
      if (bubble || !io.id_valid) begin
        ex_vld_d = 1'b0;
        ex_wr_d  = 1'b0;
        ex_ld_d  = 1'b0;
        ex_rd_d  = '0;
        sel_a_d  = SEL_RF;
        sel_b_d  = SEL_RF;
      end else begin
        ex_vld_d = 1'b1;
        ex_wr_d  = io.id_reg_write;
        ex_ld_d  = io.id_mem_read;
        ex_rd_d  = io.id_rd;
        sel_a_d  = pick_a;
        sel_b_d  = io.id_b_imm ? SEL_IMM : pick_b;
      end
      if (stall && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_vld_q  <= 1'b0;
      ex_wr_q   <= 1'b0;
      ex_ld_q   <= 1'b0;
      ex_rd_q   <= '0;
      mem_vld_q <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_rd_q  <= '0;
      sel_a_q   <= SEL_RF;
      sel_b_q   <= SEL_RF;
      cnt_q     <= '0;
    end else begin
      ex_vld_q  <= ex_vld_d;
      ex_wr_q   <= ex_wr_d;
      ex_ld_q   <= ex_ld_d;
      ex_rd_q   <= ex_rd_d;
      mem_vld_q <= mem_vld_d;
      mem_wr_q  <= mem_wr_d;
      mem_rd_q  <= mem_rd_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      cnt_q     <= cnt_d;
    end
  end

  assign io.sel_a       = sel_a_q;
  assign io.sel_b       = sel_b_q;
  assign io.stall       = stall;
  assign io.bubble      = bubble;
  assign io.stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// Directed and random checks of fwd_select_ctrl against a pipeline-slot model.
// A narrow stall counter lets saturation be reached in a short run.
module tb_fwd_select_ctrl;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_select_ctrl_if #(.REG_W(RW), .CNT_W(CW)) ifc ();

  fwd_select_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .io(ifc.slave)
  );

  typedef struct {
    bit       v;
    bit       wr;
    bit       ld;
    bit [4:0] rd;
  } slot_t;

  slot_t    m_ex, m_mem;
  bit [1:0] m_sa, m_sb;
  int       m_cnt;
  int       tests = 0;
  int       fails = 0;

  function automatic bit writes(slot_t s, bit [4:0] r);
    return s.v && s.wr && s.rd == r && r != 0;
  endfunction

  function automatic bit [1:0] src(bit [4:0] r, bit u);
    if (!u) return 2'd0;
    if (writes(m_ex, r)) return 2'd1;
    if (writes(m_mem, r)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic ins(bit v, bit [4:0] rs, bit [4:0] rt, bit urs, bit urt,
                     bit bi, bit [4:0] rd, bit wr, bit ld);
    ifc.id_valid     = v;
    ifc.id_rs        = rs;
    ifc.id_rt        = rt;
    ifc.id_use_rs    = urs;
    ifc.id_use_rt    = urt;
    ifc.id_b_imm     = bi;
    ifc.id_rd        = rd;
    ifc.id_reg_write = wr;
    ifc.id_mem_read  = ld;
  endtask

  task automatic step(bit h, bit f, bit r);
    bit    lu, e_st, e_bu;
    slot_t nx;
    ifc.hold  = h;
    ifc.flush = f;
    rst       = r;
    #1;
    lu = ifc.id_valid && m_ex.ld &&
         ((ifc.id_use_rs && writes(m_ex, ifc.id_rs)) ||
          (ifc.id_use_rt && writes(m_ex, ifc.id_rt)));
    e_st = lu && !h;
    e_bu = (lu || f) && !h;
    if (!r) begin
      check("stall", 16'(ifc.stall), 16'(e_st));
      check("bubble", 16'(ifc.bubble), 16'(e_bu));
    end
    @(posedge clk);
    if (r) begin
      m_ex = '{0, 0, 0, 0};
      m_mem = '{0, 0, 0, 0};
      m_sa = 0;
      m_sb = 0;
      m_cnt = 0;
    end else if (!h) begin
      if (e_bu || !ifc.id_valid) begin
        nx = '{0, 0, 0, 0};
        m_sa = 0;
        m_sb = 0;
      end else begin
        nx = '{1, ifc.id_reg_write, ifc.id_mem_read, ifc.id_rd};
        m_sa = src(ifc.id_rs, ifc.id_use_rs);
        m_sb = ifc.id_b_imm ? 2'd3 : src(ifc.id_rt, ifc.id_use_rt);
      end
      m_mem = m_ex;
      m_ex  = nx;
      if (e_st && m_cnt < CMAX) m_cnt++;
    end
    #1;
    check("sel_a", 16'(ifc.sel_a), 16'(m_sa));
    check("sel_b", 16'(ifc.sel_b), 16'(m_sb));
    check("stall_count", 16'(ifc.stall_count), 16'(m_cnt));
  endtask

  initial begin
    rst = 1'b1;
    ifc.hold = 1'b0;
    ifc.flush = 1'b0;
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    step(0, 0, 1);
    check("reset_sel_a", 16'(ifc.sel_a), 16'h0);

    // add $3,$1,$2 ; sub $4,$3,$5
    ins(1, 1, 2, 1, 1, 0, 3, 1, 0); step(0, 0, 0);
    ins(1, 3, 5, 1, 1, 0, 4, 1, 0); step(0, 0, 0);
    check("ex_fwd_a", 16'(ifc.sel_a), 16'h1);

    // lw $3,0($1) ; add $4,$3,$3
    ins(1, 1, 0, 1, 0, 1, 3, 1, 1); step(0, 0, 0);
    ins(1, 3, 3, 1, 1, 0, 4, 1, 0); step(0, 0, 0);
    step(0, 0, 0);
    check("lu_reissue_a", 16'(ifc.sel_a), 16'h2);
    check("lu_count", 16'(ifc.stall_count), 16'h1);

    // $0 producer, then $7 producer two back, addi $8,$7,5
    ins(1, 1, 2, 1, 1, 0, 0, 1, 0); step(0, 0, 0);
    ins(1, 0, 0, 1, 1, 0, 9, 1, 0); step(0, 0, 0);
    ins(1, 1, 2, 1, 1, 0, 7, 1, 0); step(0, 0, 0);
    ins(1, 1, 2, 1, 1, 0, 6, 1, 0); step(0, 0, 0);
    ins(1, 7, 8, 1, 0, 1, 8, 1, 0); step(0, 0, 0);
    check("two_back_b", 16'(ifc.sel_b), 16'h3);

    // hold during pending load-use
    ins(1, 1, 0, 1, 0, 1, 3, 1, 1); step(0, 0, 0);
    ins(1, 3, 3, 1, 1, 0, 4, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // store needing rt with immediate B; flush with load-use
    ins(1, 1, 0, 1, 0, 1, 5, 1, 1); step(0, 0, 0);
    ins(1, 1, 5, 1, 1, 1, 0, 0, 0); step(0, 0, 0);
    ins(1, 1, 0, 1, 0, 1, 5, 1, 1); step(0, 0, 0);
    ins(1, 5, 2, 1, 1, 0, 6, 1, 0); step(0, 1, 0);

    // reset mid-stall
    ins(1, 1, 0, 1, 0, 1, 3, 1, 1); step(0, 0, 0);
    ins(1, 3, 3, 1, 1, 0, 4, 1, 0); step(0, 0, 1);
    step(0, 0, 0);

    // randomized traffic over a small register window
    for (int i = 0; i < 400; i++) begin
      ins($urandom_range(0, 9) != 0,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), 1'($urandom),
          5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 49) == 0);
    end

    // drive the counter into saturation
    for (int i = 0; i < CMAX + 4; i++) begin
      ins(1, 1, 0, 1, 0, 1, 3, 1, 1); step(0, 0, 0);
      ins(1, 3, 3, 1, 1, 0, 4, 1, 0); step(0, 0, 0);
      step(0, 0, 0);
    end
    check("sat", 16'(ifc.stall_count), 16'(CMAX));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fwd_select_ctrl.md
Name: fwd_select_ctrl

Overview:
- Generates the registered 2-bit selector codes for the two EX-stage 4:1 operand selectors (A and B) of the 5-stage MIPS pipeline.
- Tracks the destination registers of the instructions in EX and MEM, and detects RAW hazards at issue time (ID→EX).
- Inserts a one-cycle load-use stall/bubble, so each selector is stable from the start of the EX cycle.

Parameters:
- REG_W, 5, register-index width
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- hold  in  1  global freeze (memory wait); all state holds
- flush  in  1  branch/jump taken; the instruction leaving ID this cycle becomes a bubble
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_W  source register A
- id_rt  in  REG_W  source register B
- id_use_rs  in  1  operand A reads rs
- id_use_rt  in  1  instruction reads rt (operand B or store data)
- id_b_imm  in  1  operand B is the immediate
- id_rd  in  REG_W  destination register (already muxed rt/rd/31)
- id_reg_write  in  1  instruction writes the register file
- id_mem_read  in  1  instruction is a load
- sel_a  out  2  operand-A selector for EX; registered
- sel_b  out  2  operand-B selector for EX; registered
- stall  out  1  freeze PC and IF/ID; combinational from state and ID inputs
- bubble  out  1  load zeros into ID/EX this cycle
- stall_count  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Selector encoding:
  - 00 register-file value
  - 01 EX/MEM ALU result
  - 10 MEM/WB result
  - 11 immediate (sel_b only; sel_a never 11)
- Internal state:
  - ex_vld, ex_rd, ex_wr, ex_ld: instruction now in EX
  - mem_vld, mem_rd, mem_wr: instruction now in MEM
- Reset (rst=1 at a clk edge):
  - All valid/write/load flags clear, rd fields 0.
  - sel_a=00, sel_b=00, stall_count=0.
  - stall=0 and bubble=0 follow from the cleared state.
  - Reset dominates hold and flush; any in-progress stall is abandoned.
- Hazard definitions:
  - match_ex(r) = ex_vld & ex_wr & (ex_rd==r) & (r!=0)
  - match_mem(r) = mem_vld & mem_wr & (mem_rd==r) & (r!=0)
- Load-use condition:
  - lu = id_valid & ex_ld & ((id_use_rs & match_ex(id_rs)) | (id_use_rt & match_ex(id_rt)))
  - stall = lu & ~hold
  - bubble = (lu | flush) & ~hold
- Per edge, when hold=1: every register keeps its value, including the selectors and stall_count.
- Per edge, when hold=0:
  - MEM tracking ← EX tracking (mem_vld ← ex_vld, etc.).
  - If bubble or ~id_valid: EX tracking ← invalid, sel_a=sel_b=00.
  - Otherwise EX tracking ← ID fields (ex_wr=id_reg_write, ex_ld=id_mem_read), and:
    - sel_a = match_ex(id_rs) ? 01 : match_mem(id_rs) ? 10 : 00; forced 00 when ~id_use_rs.
    - sel_b = id_b_imm ? 11 : otherwise the same rule applied to id_rt.
  - Priority: EX match over MEM match (youngest producer wins).
  - stall_count increments on each cycle with stall=1 and saturates at all-ones (no wrap).
- Latency and ordering:
  - Selectors are valid in the cycle the instruction is in EX (one cycle after issue).
  - A load-use stall lasts exactly 1 cycle: the inserted bubble clears ex_ld, so lu drops.
  - On re-issue the load is in MEM→WB, giving select 10.
- Three-apart dependence (producer in WB at issue) → 00; the register file is write-before-read.
- Register $0 never forwards, even when the producer writes it.
- A store needing rt with id_b_imm=1 takes the stall but keeps sel_b=11; store-data forwarding is outside this block.
- flush together with lu: bubble=1 and stall=1; the flushed instruction is discarded by the IF/ID flush.

Decomposition:
- Shared package constants:
  - SEL_RF=2'b00, SEL_EXMEM=2'b01, SEL_MEMWB=2'b10, SEL_IMM=2'b11
  - REG_ZERO=5'd0
- One natural sub-module, fwd_src_pick: combinational match-and-priority logic for one operand, instantiated twice.

Test Plan:
- `add $3,$1,$2` then `sub $4,$3,$5` → second instruction in EX has sel_a=01, sel_b=00; stall never asserts.
- `lw $3,0($1)` then `add $4,$3,$3` → stall=1 and bubble=1 for exactly 1 cycle, stall_count 0→1; on re-issue sel_a=10, sel_b=10.
- Producer `add $0,$1,$2` then consumer of $0 → sel_a=00; producer two back writing $7, consumer `addi $8,$7,5` → sel_a=10, sel_b=11.
- hold=1 for 3 cycles during a pending load-use → stall=0 throughout and selectors/state unchanged; the stall fires on the first cycle after hold drops.
- rst=1 mid-stall → next cycle sel_a=sel_b=00, stall=0, stall_count=0; force stall_count to all-ones and stall again → value stays all-ones.
